// File: rtl/pc_sequencer.sv
// Next-PC sequencer for the MIPS fetch stage: owns the PC, handshakes with instruction memory,
// and redirects on jumps/taken branches. Define PC_DELAY_SLOT_EN for branch-delay-slot semantics.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        branch_req,
  input  logic        branch_taken,
  input  logic        jump_req,
  input  logic [15:0] imm16,
  input  logic [25:0] jidx26,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  output logic        flush,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2,
    ST_DSLOT = 2'd3
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t      state;
  logic [3:0]  boot_cnt;
  logic [31:0] p4;
  logic [31:0] btgt;
  logic [31:0] jtgt;
  logic [31:0] redir_tgt;
  logic        redirect;
  logic        running;
  logic        accept;

  assign p4        = pc_out + 32'd4;
  assign btgt      = p4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jtgt      = {p4[31:28], jidx26, 2'b00};
  assign redirect  = jump_req | (branch_req & branch_taken);
  assign redir_tgt = jump_req ? jtgt : btgt;

  // A pending delay slot is still a fetching state; only BOOT and the REDIR bubble suppress fetch.
  assign running     = (state == ST_RUN) || (state == ST_DSLOT);
  assign fetch_valid = running & ~stall;
  assign accept      = fetch_valid & fetch_ready;
  assign state_dbg   = state;

`ifdef PC_DELAY_SLOT_EN
  logic [31:0] slot_tgt;
`endif

  // NOTE: every register below uses <= so all updates see the pre-edge values of pc_out and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out   <= RESET_VECTOR;
      state    <= ST_BOOT;
      boot_cnt <= 4'd0;
      flush    <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
      slot_tgt <= 32'd0;
`endif
    end else begin
      flush <= 1'b0;
      case (state)
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) state <= ST_RUN;
          else                       boot_cnt <= boot_cnt + 4'd1;
        end
        ST_RUN: begin
          if (accept) begin
            if (redirect) begin
`ifdef PC_DELAY_SLOT_EN
              pc_out   <= p4;
              slot_tgt <= redir_tgt;
              state    <= ST_DSLOT;
`else
              pc_out <= redir_tgt;
              flush  <= 1'b1;
              state  <= ST_REDIR;
`endif
            end else begin
              pc_out <= p4;
            end
          end
        end
        ST_REDIR: state <= ST_RUN;
        ST_DSLOT: begin
`ifdef PC_DELAY_SLOT_EN
          // Redirect inputs on the delay-slot accept are ignored; the latched target wins.
          if (accept) begin
            pc_out <= slot_tgt;
            state  <= ST_RUN;
          end
`else
          state <= ST_RUN;
`endif
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller that sequences the program counter for the MIPS fetch stage.
- Selects PC+4, the branch target or the jump target.
- Applies pipeline stalls and handshakes each fetch address with instruction memory.
- Issues a one-cycle flush on every control-flow redirect.
- Sits between the decode/branch-resolve logic and the instruction-memory address port; owns the architectural PC register.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
BOOT_CYCLES, 1, cycles fetch_valid stays low after reset is released (range 1..15).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  pipeline hazard hold; freezes PC, suppresses fetch
fetch_ready  input  1  instruction memory accepts the address this cycle
branch_req  input  1  current instruction is a conditional branch
branch_taken  input  1  branch condition true; qualified by branch_req
jump_req  input  1  current instruction is J/JAL
imm16  input  16  branch offset field, in words, signed
jidx26  input  26  jump index field
pc_out  output  32  current fetch address
fetch_valid  output  1  pc_out is a valid fetch request
flush  output  1  one-cycle pulse: discard the younger fetched instruction
state_dbg  output  2  encoded FSM state (BOOT=0, RUN=1, REDIR=2)

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - While rst=1 at a rising edge: pc_out=RESET_VECTOR, fetch_valid=0, flush=0, state=BOOT, boot counter=0.
  - rst asserted mid-operation overrides all other inputs on that edge, including a pending redirect.
- Handshake:
  - accept = fetch_valid & fetch_ready & ~stall.
  - pc_out changes only on an accept edge or on reset.
  - While fetch_valid=1 and fetch_ready=0, pc_out and fetch_valid are held stable (no retraction).
- Stall: fetch_valid = 0 combinationally while stall=1 in RUN. Stall has priority over every redirect input; requests present during a stall cycle are ignored.
- Next-PC arithmetic, all modulo 2^32:
  - p4 = pc_out + 4.
  - btgt = p4 + (sign_extend(imm16) << 2).
  - jtgt = {p4[31:28], jidx26, 2'b00}.
  - No carry-out is reported; 32'hFFFF_FFFC + 4 wraps to 32'h0.
- Selection on accept:
  - jump_req=1 -> jtgt.
  - else branch_req & branch_taken -> btgt.
  - else p4.
  - jump_req has priority when both jump_req and branch_req are set.
  - branch_taken is ignored when branch_req=0.
- FSM:
  - BOOT: fetch_valid=0; count BOOT_CYCLES cycles, then go to RUN.
  - RUN: fetch_valid=~stall. A redirect (jump or taken branch) on accept loads the target, drives flush=1 on the next cycle and goes to REDIR. Otherwise stay in RUN.
  - REDIR: exactly one cycle, fetch_valid=0 (bubble), flush=1. pc_out holds the target. Return to RUN unconditionally; stall in REDIR is irrelevant.
- Outputs: flush is registered and high only in REDIR.
- Redirect latency: target appears on pc_out one cycle after the accepting edge and is first presented with fetch_valid=1 two cycles after it.
- Alignment: pc_out[1:0] is always 2'b00, provided RESET_VECTOR is word-aligned.

Optional Feature:
Macro: PC_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - A redirect on accept loads p4, not the target.
  - The target is latched internally; flush stays 0 and there is no REDIR bubble.
  - On the next accept (the delay slot) pc_out loads the latched target.
  - Redirect inputs presented on the delay-slot accept are ignored.
  - The latched target is cleared by rst.
  - state_dbg reports 3 while the delay slot is pending.
- Undefined: behaviour exactly as above (flush plus one-cycle bubble); REDIR is used and delay-slot logic is absent.

Test Plan:
1. Reset and boot: rst=1 for 2 cycles with RESET_VECTOR=0, then fetch_ready=1 constantly -> fetch_valid rises after 1 cycle; pc_out sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles.
2. Backpressure and stall: pc_out=0x10, fetch_ready=0 for 3 cycles -> pc_out=0x10 and fetch_valid=1 held. Then stall=1 for 2 cycles -> fetch_valid=0, pc_out=0x10. Release both -> next pc_out=0x14.
3. Taken branch: at pc_out=0x40, branch_req=1, branch_taken=1, imm16=16'hFFFC -> pc_out=0x34, flush=1 for one cycle with fetch_valid=0, then fetch at 0x34. Same case with branch_taken=0 -> 0x44, no flush.
4. Jump and priority: pc_out=0x1000_0020, jump_req=1, branch_req=1, branch_taken=1, jidx26=26'h0000_100 -> pc_out=0x1000_0400, flush pulse.
5. Wrap and reset mid-redirect: pc_out=0xFFFF_FFFC accepted -> pc_out=0x0. Assert rst during REDIR -> pc_out=RESET_VECTOR, flush=0 next edge.
6. PC_DELAY_SLOT_EN defined: branch at 0x40 with imm16=16'h0004 -> pc_out 0x44 (delay slot, flush=0), then 0x54.
